// File: rtl/countdown_timer_mmss_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_mmss_pkg
// Description : Shared digit indices, digit limits and BCD helpers for the
//               MM:SS countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_timer_mmss_pkg;

  // Digit positions inside the 16-bit {min_t, min_u, sec_t, sec_u} word
  localparam int SEC_U = 0;
  localparam int SEC_T = 1;
  localparam int MIN_U = 2;
  localparam int MIN_T = 3;

  // Largest legal value of a decimal digit and of the seconds-tens digit
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;

  typedef logic [3:0] bcd_digit_t;

  // Saturate an out-of-range digit to its maximum legal value
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d, input bcd_digit_t max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_mmss_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides the system clock down to a one-cycle strobe every
//               TICK_DIV running cycles. The strobe is combinational so the
//               owner can act on the same edge the counter wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter  int TICK_DIV = 1000,
  localparam int CW       = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_sync,
  input  logic run,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance while running; hold when idle
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr_sync) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescaler count register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_mmss.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_mmss
// Description : Four-digit BCD minutes:seconds countdown with load, pause,
//               one-second tick strobe and a single done pulse on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_mmss
  import countdown_timer_mmss_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        loadn,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] time_out,
  output logic        zero,
  output logic        tick,
  output logic        done
);

  bcd_digit_t [3:0] digit_q, digit_d;
  bcd_digit_t [3:0] load_val, dec_val;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             run, clr_sync, wrap;

  assign zero     = (digit_q == '0);
  assign time_out = digit_q;
  assign tick     = tick_q;
  assign done     = done_q;

  // Count only when not loading and not already expired; a load or an idle
  // zero state restarts the partial second from scratch.
  assign run      = loadn & en & ~zero;
  assign clr_sync = ~loadn | (en & zero);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .clrn     (clrn),
    .clr_sync (clr_sync),
    .run      (run),
    .tick     (wrap)
  );

  // Sanitize the load word digit by digit
  always_comb begin
    load_val        = '0;
    load_val[SEC_U] = bcd_clamp(data[4*SEC_U +: 4], BCD_MAX);
    load_val[SEC_T] = bcd_clamp(data[4*SEC_T +: 4], SEC_T_MAX);
    load_val[MIN_U] = bcd_clamp(data[4*MIN_U +: 4], BCD_MAX);
    load_val[MIN_T] = bcd_clamp(data[4*MIN_T +: 4], BCD_MAX);
  end

  // One-second BCD borrow chain; only used when the value is non-zero
  always_comb begin
    dec_val = digit_q;
    if (digit_q[SEC_U] != 4'd0) begin
      dec_val[SEC_U] = digit_q[SEC_U] - 4'd1;
    end else begin
      dec_val[SEC_U] = BCD_MAX;
      if (digit_q[SEC_T] != 4'd0) begin
        dec_val[SEC_T] = digit_q[SEC_T] - 4'd1;
      end else begin
        dec_val[SEC_T] = SEC_T_MAX;
        if (digit_q[MIN_U] != 4'd0) begin
          dec_val[MIN_U] = digit_q[MIN_U] - 4'd1;
        end else begin
          dec_val[MIN_U] = BCD_MAX;
          dec_val[MIN_T] = digit_q[MIN_T] - 4'd1;
        end
      end
    end
  end

  // Next digits and strobes: load beats counting, strobes default low
  always_comb begin
    digit_d = digit_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (!loadn) begin
      digit_d = load_val;
    end else if (wrap) begin
      digit_d = dec_val;
      tick_d  = 1'b1;
      done_d  = (dec_val == '0);
    end
  end

  // Digit and strobe registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      digit_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire
